// File: rtl/reg_file_param_pkg.sv
// Shared CPU constants for the parameterised register file.
// Holds the parameter defaults and the scrub FSM state encodings.
package reg_file_param_pkg;

  // Parameter defaults used by reg_file_param and reg_scrub_ctrl
  localparam int WIDTH_DEFAULT    = 8;
  localparam int ADDR_W_DEFAULT   = 3;
  localparam int ZERO_REG_DEFAULT = 0;
  localparam int BYPASS_DEFAULT   = 1;

  // Scrub FSM state encodings
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SCRUB = 1'b1;

endpackage : reg_file_param_pkg

// File: rtl/reg_scrub_ctrl.sv
// Scrub controller: walks a pointer over every register address once,
// one address per cycle, after CLEAR is seen in IDLE.
module reg_scrub_ctrl
  import reg_file_param_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  output logic              BUSY,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [0:0] state;

  // State and pointer update; the pointer parks on the last address at scrub end
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CLEAR) begin
            state <= ST_SCRUB;
            ptr   <= '0;
          end
        end
        ST_SCRUB: begin
          if (ptr == LAST_ADDR) begin
            state <= ST_IDLE;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = (state == ST_SCRUB);

endmodule : reg_scrub_ctrl

// File: rtl/reg_file_param.sv
// Parameterised two-read, one-write register file with per-register valid
// bits, optional hardwired-zero register 0, optional write-to-read forwarding
// and a background scrub that clears every register over DEPTH cycles.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  parameter int BYPASS   = BYPASS_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [WIDTH-1:0]  OUT1,
  output logic [WIDTH-1:0]  OUT2,
  output logic              VALID1,
  output logic              VALID2,
  input  logic              CLEAR,
  output logic              BUSY,
  output logic              DROPPED
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  regs [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] scrub_ptr;
  logic              zero_hit;
  logic              wr_acc;
  logic              wr_drop;

  reg_scrub_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_scrub (
    .CLK   (CLK),
    .RESET (RESET),
    .CLEAR (CLEAR),
    .BUSY  (BUSY),
    .ptr   (scrub_ptr)
  );

  // Writes to a hardwired-zero register 0 vanish silently: neither stored nor reported
  assign zero_hit = (ZERO_REG != 0) && (INADDRESS == '0);
  assign wr_acc   = RESET && WRITE && !BUSY && !zero_hit;
  assign wr_drop  = RESET && WRITE &&  BUSY && !zero_hit;

  // Storage and valid bits: scrub clears one entry per cycle, otherwise accept writes
  // NOTE: this storage is flop-based and must read as zero after reset, so every entry is reset; a RAM macro would not be.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      valid_q <= '0;
    end else if (BUSY) begin
      regs[scrub_ptr]    <= '0;
      valid_q[scrub_ptr] <= 1'b0;
    end else if (wr_acc) begin
      regs[INADDRESS]    <= IN;
      valid_q[INADDRESS] <= 1'b1;
    end
  end

  // One-cycle pulse reporting a write rejected because a scrub was running
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      DROPPED <= 1'b0;
    end else begin
      DROPPED <= wr_drop;
    end
  end

  // Read port 1: stored value, overridden by forwarding, then by the zero register
  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    OUT1   = regs[OUT1ADDRESS];
    VALID1 = valid_q[OUT1ADDRESS];
    if ((BYPASS != 0) && wr_acc && (INADDRESS == OUT1ADDRESS)) begin
      OUT1   = IN;
      VALID1 = 1'b1;
    end
    if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) begin
      OUT1   = '0;
      VALID1 = 1'b1;
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    OUT2   = regs[OUT2ADDRESS];
    VALID2 = valid_q[OUT2ADDRESS];
    if ((BYPASS != 0) && wr_acc && (INADDRESS == OUT2ADDRESS)) begin
      OUT2   = IN;
      VALID2 = 1'b1;
    end
    if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) begin
      OUT2   = '0;
      VALID2 = 1'b1;
    end
  end

endmodule : reg_file_param

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param. Three configurations share stimulus:
// 0 = BYPASS on, 1 = BYPASS off, 2 = ZERO_REG on with BYPASS on.
module tb_reg_file_param;

  localparam int NC = 3;
  localparam int D  = 8;

  logic       CLK = 1'b0;
  logic       RESET, WRITE, CLEAR;
  logic [7:0] IN;
  logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS;

  wire [7:0] o1 [NC];
  wire [7:0] o2 [NC];
  wire       v1 [NC];
  wire       v2 [NC];
  wire       busy [NC];
  wire       drop [NC];

  reg_file_param #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_byp (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(o1[0]), .OUT2(o2[0]), .VALID1(v1[0]), .VALID2(v2[0]),
    .CLEAR(CLEAR), .BUSY(busy[0]), .DROPPED(drop[0]));

  reg_file_param #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_nobyp (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(o1[1]), .OUT2(o2[1]), .VALID1(v1[1]), .VALID2(v2[1]),
    .CLEAR(CLEAR), .BUSY(busy[1]), .DROPPED(drop[1]));

  reg_file_param #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_zero (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(o1[2]), .OUT2(o2[2]), .VALID1(v1[2]), .VALID2(v2[2]),
    .CLEAR(CLEAR), .BUSY(busy[2]), .DROPPED(drop[2]));

  initial forever #5 CLK = ~CLK;

  typedef struct packed {
    logic [NC-1:0][7:0] out1;
    logic [NC-1:0][7:0] out2;
    logic [NC-1:0]      v1;
    logic [NC-1:0]      v2;
    logic [NC-1:0]      busy;
    logic [NC-1:0]      drop;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: plain arrays, a busy flag and a scrub index per configuration
  logic [7:0] m_mem  [NC][D];
  bit         m_vld  [NC][D];
  bit         m_busy [NC];
  int         m_idx  [NC];
  bit         m_drop [NC];

  function automatic bit cfg_byp(input int c);
    return c != 1;
  endfunction

  function automatic bit cfg_zero(input int c);
    return c == 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void read_model(input int c, input logic [2:0] a, input bit acc,
                                     output logic [7:0] d, output logic v);
    if (cfg_zero(c) && a == 3'd0) begin
      d = 8'h00; v = 1'b1;
    end else if (cfg_byp(c) && acc && a == INADDRESS) begin
      d = IN;    v = 1'b1;
    end else begin
      d = m_mem[c][a]; v = m_vld[c][a];
    end
  endfunction

  function automatic exp_t predict();
    exp_t       e;
    logic [7:0] d;
    logic       v;
    bit         acc;
    e = '0;
    for (int c = 0; c < NC; c++) begin
      acc = RESET && WRITE && !m_busy[c] && !(cfg_zero(c) && INADDRESS == 3'd0);
      read_model(c, OUT1ADDRESS, acc, d, v);
      e.out1[c] = d; e.v1[c] = v;
      read_model(c, OUT2ADDRESS, acc, d, v);
      e.out2[c] = d; e.v2[c] = v;
      e.busy[c] = m_busy[c];
      e.drop[c] = m_drop[c];
    end
    return e;
  endfunction

  task automatic model_edge();
    bit zw;
    bit nd;
    for (int c = 0; c < NC; c++) begin
      if (!RESET) begin
        for (int a = 0; a < D; a++) begin
          m_mem[c][a] = 8'h00;
          m_vld[c][a] = 1'b0;
        end
        m_busy[c] = 1'b0;
        m_idx[c]  = 0;
        m_drop[c] = 1'b0;
      end else begin
        zw = cfg_zero(c) && INADDRESS == 3'd0;
        nd = WRITE && m_busy[c] && !zw;
        if (!m_busy[c]) begin
          if (WRITE && !zw) begin
            m_mem[c][INADDRESS] = IN;
            m_vld[c][INADDRESS] = 1'b1;
          end
          if (CLEAR) begin
            m_busy[c] = 1'b1;
            m_idx[c]  = 0;
          end
        end else begin
          m_mem[c][m_idx[c]] = 8'h00;
          m_vld[c][m_idx[c]] = 1'b0;
          if (m_idx[c] == D - 1) m_busy[c] = 1'b0;
          else                   m_idx[c]  = m_idx[c] + 1;
        end
        m_drop[c] = nd;
      end
    end
  endtask

  // Apply one cycle of stimulus, queue its expected response, advance the model at the edge
  task automatic drive(input bit rst, input bit wr, input int wa, input logic [7:0] din,
                       input bit clr, input int a1, input int a2);
    RESET       = rst;
    WRITE       = wr;
    INADDRESS   = 3'(wa);
    IN          = din;
    CLEAR       = clr;
    OUT1ADDRESS = 3'(a1);
    OUT2ADDRESS = 3'(a2);
    exp_q.push_back(predict());
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int c = 0; c < NC; c++) begin
          check($sformatf("c%0d_out1", c),    32'(o1[c]),   32'(e.out1[c]));
          check($sformatf("c%0d_out2", c),    32'(o2[c]),   32'(e.out2[c]));
          check($sformatf("c%0d_valid1", c),  32'(v1[c]),   32'(e.v1[c]));
          check($sformatf("c%0d_valid2", c),  32'(v2[c]),   32'(e.v2[c]));
          check($sformatf("c%0d_busy", c),    32'(busy[c]), 32'(e.busy[c]));
          check($sformatf("c%0d_dropped", c), 32'(drop[c]), 32'(e.drop[c]));
        end
      end
    end
  end

  initial begin
    RESET = 1'b0; WRITE = 1'b0; CLEAR = 1'b0; IN = 8'h00;
    INADDRESS = 3'd0; OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
    @(posedge CLK);
    model_edge();
    #1;

    // Reset state on addresses 0 and 1
    drive(1, 0, 0, 8'h00, 0, 0, 1);

    // Write 8'h1F to address 2 while reading it: forwarded only with BYPASS
    drive(1, 1, 2, 8'h1F, 0, 2, 3);
    drive(1, 0, 0, 8'h00, 0, 2, 2);

    // Load A0..A7, then scrub; drop a write on scrub cycle 3, ignore CLEAR on cycle 5
    for (int k = 0; k < D; k++) drive(1, 1, k, 8'hA0 + 8'(k), 0, k, (k + 7) % D);
    drive(1, 0, 0, 8'h00, 1, 0, 1);
    for (int s = 1; s <= D; s++) drive(1, s == 3, 4, 8'h55, s == 5, s - 1, 4);
    drive(1, 0, 0, 8'h00, 0, 4, 7);
    drive(1, 0, 0, 8'h00, 0, 0, 3);

    // Reset on scrub cycle 4 aborts the scrub; a fresh CLEAR runs a full scrub
    for (int k = 0; k < D; k++) drive(1, 1, k, 8'hA0 + 8'(k), 0, k, 0);
    drive(1, 0, 0, 8'h00, 1, 5, 6);
    for (int s = 1; s <= 3; s++) drive(1, 0, 0, 8'h00, 0, s + 3, 7);
    drive(0, 1, 5, 8'h77, 1, 5, 7);
    drive(1, 0, 0, 8'h00, 0, 5, 7);
    drive(1, 1, 6, 8'h3C, 1, 6, 0);
    for (int s = 1; s <= D + 1; s++) drive(1, 0, 0, 8'h00, 0, 6, s % D);

    // Hardwired zero register: write 8'hFF to address 0
    drive(1, 1, 0, 8'hFF, 0, 0, 0);
    drive(1, 0, 0, 8'h00, 0, 0, 1);

    // Randomised traffic with occasional resets and scrubs
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), 8'($urandom),
            $urandom_range(0, 15) == 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    @(negedge CLK);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_file_param

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every register and data port.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; register count DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 0; when 1, register 0 is hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to the read ports.
REQ-005 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port RESET  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port IN  input  WIDTH  write data.
REQ-008 SHALL have port INADDRESS  input  ADDR_W  write address.
REQ-009 SHALL have port WRITE  input  1  write enable.
REQ-010 SHALL have ports OUT1ADDRESS and OUT2ADDRESS  input  ADDR_W  read addresses, ports 1 and 2.
REQ-011 SHALL have ports OUT1 and OUT2  output  WIDTH  read data, ports 1 and 2.
REQ-012 SHALL have ports VALID1 and VALID2  output  1  addressed register written since last reset or scrub.
REQ-013 SHALL have port CLEAR  input  1  request to start a scrub of all registers.
REQ-014 SHALL have port BUSY  output  1  scrub in progress.
REQ-015 SHALL have port DROPPED  output  1  one-cycle pulse: a write was rejected.

Function
REQ-016 Write accepted at rising edge when RESET=1, WRITE=1, state IDLE, and not (ZERO_REG=1 and INADDRESS=0): REG[INADDRESS]<=IN, valid[INADDRESS]<=1.
REQ-017 Reads combinational, no modelled delays: OUTx=REG[OUTxADDRESS], VALIDx=valid[OUTxADDRESS].
REQ-018 BYPASS=1 and write accepted this cycle with INADDRESS==OUTxADDRESS: OUTx=IN, VALIDx=1 (write-first); BYPASS=0: OUTx shows the pre-edge value.
REQ-019 ZERO_REG=1: read of address 0 returns 0 with VALIDx=1; writes to address 0 are ignored without a DROPPED pulse.
REQ-020 Scrub FSM states: IDLE, SCRUB; BUSY=1 exactly while state is SCRUB.
REQ-021 IDLE with CLEAR=1 at an edge: next state SCRUB, pointer<=0; a WRITE in that same cycle is still accepted.
REQ-022 Each SCRUB cycle: REG[pointer]<=0, valid[pointer]<=0, pointer<=pointer+1; when pointer==DEPTH-1, next state IDLE.
REQ-023 Scrub lasts exactly DEPTH cycles; BUSY high DEPTH cycles starting the cycle after CLEAR is sampled.
REQ-024 CLEAR while in SCRUB is ignored; scrub does not restart or extend.
REQ-025 WRITE=1 in SCRUB: write dropped, DROPPED=1 in the following cycle, forwarding suppressed.
REQ-026 Reads during SCRUB return current contents, including partially cleared registers.
REQ-027 Pointer is ADDR_W bits and SHALL NOT wrap past DEPTH-1 within a scrub.

Reset
REQ-028 RESET=0 at a rising edge: all registers 0, all valid bits 0, state IDLE, pointer 0, BUSY 0, DROPPED 0, in one cycle.
REQ-029 RESET dominates WRITE and CLEAR in the same cycle; reset mid-scrub aborts it and returns to IDLE.
REQ-030 After reset, OUT1/OUT2 read 0 and VALID1/VALID2 read 0 for every address.

Structure
REQ-031 FSM state encodings (IDLE, SCRUB) SHALL live in the shared CPU constants package, with the parameter defaults.
REQ-032 Scrub FSM and pointer SHALL be sub-module reg_scrub_ctrl; storage, valid bits and read muxes stay in reg_file_param.

Verification (WIDTH=8, ADDR_W=3)
REQ-033 Reset low one edge, then read addresses 0 and 1 -> OUT1=OUT2=8'h00, VALID1=VALID2=0.
REQ-034 Write 8'h1F to address 2, OUT1ADDRESS=2 same cycle, BYPASS=1 -> OUT1=8'h1F before edge, VALID1=1; BYPASS=0 -> 8'h00 until edge.
REQ-035 Load 8'hA0..8'hA7 into addresses 0..7, pulse CLEAR -> BUSY high 8 cycles, address k reads 8'h00 from scrub cycle k+1, all valid 0 after.
REQ-036 WRITE 8'h55 to address 4 on scrub cycle 3 -> DROPPED pulses next cycle, address 4 reads 8'h00 after scrub.
REQ-037 RESET low on scrub cycle 4 -> BUSY 0 next cycle, all registers 8'h00; CLEAR then restarts a full 8-cycle scrub.
REQ-038 ZERO_REG=1, write 8'hFF to address 0 -> OUT1 at address 0 reads 8'h00, VALID1=1, DROPPED stays 0.
